mvu_out_stage: RTL and testbench

// Flow-control and result-capture stage wrapped around the LUT MVU compute core.
// - Gates the core's global enable from an upstream AXI-Stream-like input handshake.
// - Drives the core's last/zero control inputs; drains in-flight accumulations when input stalls.
// - Captures each completed PE accumulator vector into a small FIFO presented as an AXI-Stream master.

---
 rtl/mvu_out_stage_pkg.sv | 16 +
 rtl/mvu_out_stage_result_fifo.sv | 48 ++++
 rtl/mvu_out_stage.sv | 82 ++++++++
 tb/tb_mvu_out_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_out_stage_pkg.sv
// Shared sizing and types for the LUT MVU output stage.
// The compute core and the result FIFO both use the accumulator vector layout defined here.
package mvu_pkg;
  localparam int PE         = 4;
  localparam int ACCU_WIDTH = 32;
  localparam int DEPTH      = 4;
  localparam int CORE_LAT   = 2;

  localparam int VEC_W = PE * ACCU_WIDTH;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int INF_W = $clog2(CORE_LAT + 2);

  // PE 0 sits in the least significant ACCU_WIDTH bits.
  typedef logic signed [PE-1:0][ACCU_WIDTH-1:0] accu_vec_t;
endpackage

// File: rtl/mvu_out_stage_result_fifo.sv
// Circular buffer holding completed accumulator vectors until the downstream consumer takes them.
// The read word comes straight from storage registers and reads as zero while the buffer is empty.
module mvu_result_fifo
  import mvu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  accu_vec_t        push_data,
  input  logic             pop,
  output accu_vec_t        rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  accu_vec_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  // A push into a full buffer is dropped, even when a pop happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/mvu_out_stage.sv
// Flow control around the LUT MVU core: gates its enable from the input stream, drains
// in-flight accumulations when input stalls, and queues finished vectors for the output stream.
module mvu_out_stage
  import mvu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             core_en,
  output logic             core_last,
  output logic             core_zero,
  input  logic             core_vld,
  input  logic [VEC_W-1:0] core_p,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [VEC_W-1:0] m_tdata
);
  // Handshakes: a beat transfers on a cycle where valid & ready are both high; valid never
  // waits for ready, and a presented m_tdata/m_tvalid holds until it is taken.
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  accu_vec_t        fifo_rd;
  logic             space;
  logic             drain;
  logic             push;
  logic             pop;
  logic             inf_inc;
  logic             inf_dec;
  logic [INF_W-1:0] inflight;

  // Room is judged from the registered count alone, so m_tready never reaches s_ready/core_en.
  assign space     = (fifo_count < CNT_W'(DEPTH));
  assign drain     = ~s_valid & (inflight != '0);
  assign s_ready   = space & ~rst;
  assign core_en   = space & (s_valid | drain) & ~rst;
  assign core_last = core_en & s_valid & s_last;
  assign core_zero = core_en & drain;

  assign inf_inc = core_en & core_last;
  assign inf_dec = core_en & core_vld;
  assign push    = core_en & core_vld;
  assign pop     = m_tvalid & m_tready;

  assign m_tvalid = ~fifo_empty;
  assign m_tdata  = fifo_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({inf_inc, inf_dec})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  mvu_result_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (core_p),
    .pop       (pop),
    .rd_data   (fifo_rd),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(core_en && core_vld && inflight == '0))
        else $error("mvu_out_stage: core result with no accumulation in flight");
      assert (!(push && fifo_full))
        else $error("mvu_out_stage: push into full result fifo");
    end
  end
endmodule

// File: tb/tb_mvu_out_stage.sv
// Directed bench for mvu_out_stage with a behavioural two-stage core model (CORE_LAT=2).
module tb_mvu_out_stage;
  import mvu_pkg::*;

  logic             clk;
  logic             rst;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic             core_en;
  logic             core_last;
  logic             core_zero;
  logic             core_vld;
  logic [VEC_W-1:0] core_p;
  logic             m_tvalid;
  logic             m_tready;
  logic [VEC_W-1:0] m_tdata;
  logic [VEC_W-1:0] beat;

  int checks   = 0;
  int failures = 0;

  mvu_out_stage dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .core_en   (core_en),
    .core_last (core_last),
    .core_zero (core_zero),
    .core_vld  (core_vld),
    .core_p    (core_p),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // core model: accumulate per lane, then two enable-qualified register stages to core_vld
  accu_vec_t acc, s1_p, s2_p;
  logic      s1_vld, s2_vld;

  function automatic accu_vec_t add_vec(input accu_vec_t a, input accu_vec_t b);
    accu_vec_t r;
    for (int i = 0; i < PE; i++) r[i] = a[i] + b[i];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      s1_p   <= '0;
      s2_p   <= '0;
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else if (core_en) begin
      if (core_last) begin
        s1_p <= add_vec(acc, core_zero ? '0 : beat);
        acc  <= '0;
      end else begin
        acc  <= add_vec(acc, core_zero ? '0 : beat);
      end
      s1_vld <= core_last;
      s2_vld <= s1_vld;
      s2_p   <= s1_p;
    end
  end

  assign core_vld = s2_vld;
  assign core_p   = s2_p;

  // driver tasks and checkers
  task automatic drv(input logic v, input logic l, input logic [VEC_W-1:0] d);
    s_valid = v;
    s_last  = l;
    beat    = d;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
  endtask

  task automatic chkv(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  logic [VEC_W-1:0] b1, b2, b3, sum1, dv, sg;
  logic [VEC_W-1:0] e [6];
  logic [VEC_W-1:0] f0, f1, f2;

  initial begin
    b1   = {32'd4, 32'd3, 32'd2, 32'd1};
    b2   = {32'd40, 32'd30, 32'd20, 32'd10};
    b3   = {32'd400, 32'd300, 32'd200, 32'd100};
    sum1 = {32'd444, 32'd333, 32'd222, 32'd111};
    dv   = {32'd7, 32'hFFFF_FFFE, 32'd0, 32'h1234_5678};
    sg   = {32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
    f0   = {32'd11, 32'd12, 32'd13, 32'd14};
    f1   = {32'd21, 32'd22, 32'd23, 32'd24};
    f2   = {32'd31, 32'd32, 32'd33, 32'd34};
    for (int i = 0; i < 6; i++)
      e[i] = {32'(i * 1000 + 4), 32'(i * 100 + 3), 32'(i * 10 + 2), 32'(i + 1)};

    // reset: input valid is asserted to show nothing leaks through while rst is high
    rst = 1'b1; m_tready = 1'b0;
    drv(1'b1, 1'b1, b1);
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_s_ready", s_ready, 1'b0);
    chk1("rst_core_en", core_en, 1'b0);
    chk1("rst_core_last", core_last, 1'b0);
    chk1("rst_core_zero", core_zero, 1'b0);
    chk1("rst_m_tvalid", m_tvalid, 1'b0);
    chkv("rst_m_tdata", m_tdata, '0);

    // single dot product, input kept busy with zero-valued beats afterwards
    @(negedge clk); rst = 1'b0; m_tready = 1'b1; drv(1'b1, 1'b0, b1); #1;
    chk1("t1_s_ready", s_ready, 1'b1);
    chk1("t1_core_en", core_en, 1'b1);
    chk1("t1_zero_b1", core_zero, 1'b0);
    @(negedge clk); drv(1'b1, 1'b0, b2); #1;
    chk1("t1_last_b2", core_last, 1'b0);
    @(negedge clk); drv(1'b1, 1'b1, b3); #1;
    chk1("t1_last_b3", core_last, 1'b1);
    chk1("t1_zero_b3", core_zero, 1'b0);
    @(negedge clk); drv(1'b1, 1'b0, '0); #1;
    chk1("t1_zero_p1", core_zero, 1'b0);
    chk1("t1_tvalid_p1", m_tvalid, 1'b0);
    @(negedge clk); drv(1'b1, 1'b0, '0); #1;
    chk1("t1_zero_push", core_zero, 1'b0);
    chk1("t1_vld_push", core_vld, 1'b1);
    chk1("t1_tvalid_push", m_tvalid, 1'b0);
    @(negedge clk); drv(1'b0, 1'b0, '0); #1;
    chk1("t1_tvalid", m_tvalid, 1'b1);
    chkv("t1_tdata", m_tdata, sum1);
    chk1("t1_idle_en", core_en, 1'b0);
    chk1("t1_idle_zero", core_zero, 1'b0);

    // stall drain after a single closing beat
    @(negedge clk); drv(1'b1, 1'b1, dv); #1;
    chk1("t2_tvalid_popped", m_tvalid, 1'b0);
    chk1("t2_last", core_last, 1'b1);
    @(negedge clk); drv(1'b0, 1'b0, '0); #1;
    chk1("t2_d1_en", core_en, 1'b1);
    chk1("t2_d1_zero", core_zero, 1'b1);
    chk1("t2_d1_last", core_last, 1'b0);
    @(negedge clk); #1;
    chk1("t2_d2_en", core_en, 1'b1);
    chk1("t2_d2_zero", core_zero, 1'b1);
    chk1("t2_d2_tvalid", m_tvalid, 1'b0);
    @(negedge clk); #1;
    chk1("t2_done_en", core_en, 1'b0);
    chk1("t2_done_zero", core_zero, 1'b0);
    chk1("t2_tvalid", m_tvalid, 1'b1);
    chkv("t2_tdata", m_tdata, dv);
    @(negedge clk); #1;
    chk1("t2_one_result", m_tvalid, 1'b0);

    // backpressure: six single-beat results with the consumer stalled
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drv(1'b1, 1'b1, e[i]); #1;
      chk1($sformatf("t3_accept%0d", i), s_ready, 1'b1);
    end
    @(negedge clk); drv(1'b0, 1'b0, '0); #1;
    chk1("t3_full_s_ready", s_ready, 1'b0);
    chk1("t3_full_core_en", core_en, 1'b0);
    chk1("t3_full_tvalid", m_tvalid, 1'b1);
    chkv("t3_full_tdata", m_tdata, e[0]);
    repeat (2) begin
      @(negedge clk); #1;
      chkv("t3_hold_tdata", m_tdata, e[0]);
      chk1("t3_hold_s_ready", s_ready, 1'b0);
    end

    // full + single-cycle pop: room appears only on the following cycle
    @(negedge clk); m_tready = 1'b1; #1;
    chk1("t4_same_cycle_s_ready", s_ready, 1'b0);
    chkv("t4_pop_tdata", m_tdata, e[0]);
    @(negedge clk); m_tready = 1'b0; #1;
    chk1("t4_next_s_ready", s_ready, 1'b1);
    chk1("t4_drain_zero", core_zero, 1'b1);
    chkv("t4_next_tdata", m_tdata, e[1]);
    @(negedge clk); #1;
    chk1("t4_refull_s_ready", s_ready, 1'b0);
    chk1("t4_refull_core_en", core_en, 1'b0);
    @(negedge clk); m_tready = 1'b1; #1;
    chkv("t3_out1", m_tdata, e[1]);
    for (int i = 2; i < 6; i++) begin
      @(negedge clk); #1;
      chk1($sformatf("t3_tvalid%0d", i), m_tvalid, 1'b1);
      chkv($sformatf("t3_out%0d", i), m_tdata, e[i]);
    end
    @(negedge clk); #1;
    chk1("t3_drained_tvalid", m_tvalid, 1'b0);
    chk1("t3_drained_core_en", core_en, 1'b0);

    // signed lane placement
    @(negedge clk); drv(1'b1, 1'b1, sg); #1;
    @(negedge clk); drv(1'b0, 1'b0, '0); #1;
    chk1("t5_drain_zero", core_zero, 1'b1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk1("t5_tvalid", m_tvalid, 1'b1);
    chkv("t5_pe0", {96'd0, m_tdata[31:0]}, {96'd0, 32'hFFFF_FFFF});
    chkv("t5_pe3", {96'd0, m_tdata[127:96]}, {96'd0, 32'h7FFF_FFFF});
    chkv("t5_word", m_tdata, sg);

    // reset with two results queued and one accumulation in flight
    @(negedge clk); m_tready = 1'b0; drv(1'b1, 1'b1, f0); #1;
    @(negedge clk); drv(1'b1, 1'b1, f1); #1;
    @(negedge clk); drv(1'b1, 1'b1, f2); #1;
    @(negedge clk); drv(1'b0, 1'b0, '0); #1;
    chk1("t6_drain_en", core_en, 1'b1);
    @(negedge clk); rst = 1'b1; #1;
    chk1("t6_pre_tvalid", m_tvalid, 1'b1);
    chkv("t6_pre_tdata", m_tdata, f0);
    chk1("t6_rst_s_ready", s_ready, 1'b0);
    chk1("t6_rst_core_en", core_en, 1'b0);
    chk1("t6_rst_core_zero", core_zero, 1'b0);
    @(negedge clk); #1;
    chk1("t6_rst_tvalid", m_tvalid, 1'b0);
    chk1("t6_rst_s_ready2", s_ready, 1'b0);
    rst = 1'b0; m_tready = 1'b1; #1;
    chk1("t6_rel_s_ready", s_ready, 1'b1);
    chk1("t6_rel_core_en", core_en, 1'b0);
    chk1("t6_rel_core_zero", core_zero, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk1($sformatf("t6_no_stale%0d", i), m_tvalid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
